sdram_traffic_checker: RTL and testbench
========================================

// Module: sdram_traffic_checker
// PURPOSE
//  Self-checking traffic source and sink that sits directly upstream and downstream of sdram_pro_axi_top.
//  It writes a deterministic word stream into the controller's write FIFO.
//  It then raises read_valid, drains the read FIFO, and compares every returned word against the same stream.
//  Used in board bring-up and in the top-level bench in place of hand-driven stimulus.
// PARAMETERS
//  DATA_W       16     data word width; matches the SDRAM dq width
//  CNT_W        10     width of the FIFO fill-level inputs
//  FIFO_DEPTH   512    write-FIFO depth in words; WRITE stalls at FIFO_DEPTH-2 (2-word guard)
//  TOTAL_WORDS  1024   words per pass, in the range 1..65535
//  SEED         16'h0  first pattern word; pattern[i] = SEED + i mod 2^DATA_W
//  TIMEOUT_CYC  20'hFFFFF  idle cycles without progress before an abort
// PORTS
//  sys_clk          in   1       system clock; all logic is on its rising edge
//  sys_rst_n        in   1       asynchronous, active-low reset
//  start            in   1       one-cycle pulse that begins a pass; honoured only in IDLE
//  init_end         in   1       SDRAM initialisation complete
//  wr_fifo_wr_en    out  1       write-FIFO push strobe
//  wr_fifo_wr_data  out  DATA_W  word pushed while wr_fifo_wr_en=1
//  wr_fifo_num      in   CNT_W   write-FIFO fill level
//  read_valid       out  1       requests the controller to fetch SDRAM data into the read FIFO
//  rd_fifo_rd_req   out  1       read-FIFO pop strobe
//  rd_fifo_rd_data  in   DATA_W  popped word; valid exactly 1 cycle after rd_fifo_rd_req (normal mode, no show-ahead)
//  rd_fifo_num      in   CNT_W   read-FIFO fill level
//  busy             out  1       high in every state except IDLE and DONE
//  done             out  1       level, high in DONE
//  pass             out  1       valid while done=1: err_cnt==0 and timeout==0
//  timeout          out  1       set on a watchdog abort; cleared only by start or reset
//  err_cnt          out  16      mismatch count; saturates at 16'hFFFF
//  err_first_idx    out  16      word index of the first mismatch; 16'hFFFF if there is none
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; all outputs 0 except err_first_idx=16'hFFFF.
//  Counters wr_idx, rd_issued and rd_got cleared to 0.
//  FSM states: IDLE, WRITE, FLUSH, READ, DONE.
//   IDLE: when start=1 and init_end=1, clear counters, err_cnt, timeout and err_first_idx, then go to WRITE.
//     start while init_end=0 is dropped; it is not queued.
//   WRITE: wr_fifo_wr_en=1 in any cycle where wr_fifo_num < FIFO_DEPTH-2 and wr_idx < TOTAL_WORDS.
//     wr_fifo_wr_data = SEED + wr_idx, registered together with the strobe; wr_idx++ per push.
//     After the push with wr_idx = TOTAL_WORDS-1, go to FLUSH.
//   FLUSH: wait until wr_fifo_num==0 for 2 consecutive cycles, covering FIFO count latency, then go to READ.
//   READ: read_valid=1 for the whole state.
//     rd_fifo_rd_req=1 when rd_fifo_num!=0 and rd_issued < TOTAL_WORDS.
//     Two back-to-back pops with rd_fifo_num==1 are forbidden: the 2nd pop requires rd_fifo_num>=2.
//     Each returned word (1 cycle after its req) is compared against expected = SEED + rd_got, then rd_got++.
//     Mismatch: err_cnt++ (saturating); err_first_idx = rd_got if still 16'hFFFF.
//     When rd_got==TOTAL_WORDS, drop read_valid the same cycle and go to DONE.
//   DONE: done=1, pass valid. A start here re-runs the pass exactly as from IDLE; init_end is not rechecked.
//  Watchdog: a 20-bit counter, active in WRITE, FLUSH and READ.
//   Cleared on any push, pop, or state change; otherwise increments.
//   At TIMEOUT_CYC: timeout=1, read_valid=0, go to DONE (pass=0); in-flight returned data is discarded.
//  start outside IDLE and DONE is ignored.
//  init_end falling mid-pass is ignored; it is sampled only on entry.
//  Index arithmetic is 16-bit unsigned; the pattern wraps modulo 2^DATA_W (e.g. SEED=16'hFFFF gives FFFF,0000,0001...).
//  Reset mid-pass aborts immediately; strobes drop asynchronously; no partial result is kept.
// TESTING
//  T1 Nominal: SEED=0, TOTAL_WORDS=1024, against the controller and SDRAM model -> done=1, pass=1, err_cnt=0, err_first_idx=FFFF.
//  T2 Fault: a bench FIFO corrupts word index 37 (XOR 16'h0001) -> err_cnt=1, err_first_idx=37, pass=0.
//  T3 Backpressure: hold wr_fifo_num=FIFO_DEPTH-2 for 100 cycles -> no wr_fifo_wr_en; resumes next cycle after release; no word is lost or duplicated.
//  T4 Wrap: SEED=16'hFFFE, TOTAL_WORDS=4 -> pushes FFFE,FFFF,0000,0001; pass=1.
//  T5 Timeout: TIMEOUT_CYC=1000, rd_fifo_num stuck at 0 in READ -> timeout=1, done=1, pass=0 after 1000 idle cycles.
//  T6 Control: start with init_end=0 -> stays IDLE; reset pulse mid-WRITE -> all outputs at reset values, state=IDLE.

Source files
------------

// File: rtl/sdram_traffic_checker.sv
// sdram_traffic_checker: self-checking traffic source/sink for the SDRAM controller FIFOs.
// Writes pattern[i] = SEED + i into the write FIFO, waits for it to drain, then
// raises read_valid, pops the read FIFO and compares every word against the pattern.
// Ports:
//   sys_clk, sys_rst_n                 clock, async active-low reset
//   start, init_end                    pass trigger, SDRAM init complete
//   wr_fifo_wr_en/_wr_data, wr_fifo_num   write-FIFO push side and fill level
//   read_valid                         read-fetch request to the controller
//   rd_fifo_rd_req/_rd_data, rd_fifo_num  read-FIFO pop side (data 1 cycle after req)
//   busy, done, pass, timeout          status
//   err_cnt, err_first_idx             mismatch count and first mismatching index
module sdram_traffic_checker #(
   parameter int unsigned       DATA_W      = 16,
   parameter int unsigned       CNT_W       = 10,
   parameter int unsigned       FIFO_DEPTH  = 512,
   parameter int unsigned       TOTAL_WORDS = 1024,
   parameter logic [DATA_W-1:0] SEED        = '0,
   parameter logic [19:0]       TIMEOUT_CYC = 20'hFFFFF
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              start,
   input  logic              init_end,
   output logic              wr_fifo_wr_en,
   output logic [DATA_W-1:0] wr_fifo_wr_data,
   input  logic [CNT_W-1:0]  wr_fifo_num,
   output logic              read_valid,
   output logic              rd_fifo_rd_req,
   input  logic [DATA_W-1:0] rd_fifo_rd_data,
   input  logic [CNT_W-1:0]  rd_fifo_num,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [15:0]       err_cnt,
   output logic [15:0]       err_first_idx
);

   localparam int unsigned      IDX_W     = 16;
   localparam int unsigned      WD_W      = 20;
   localparam logic [CNT_W-1:0] WR_LIMIT  = CNT_W'(FIFO_DEPTH - 2);
   localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(TOTAL_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL_WORDS - 1);
   localparam logic [WD_W-1:0]  WD_LAST   = TIMEOUT_CYC - 20'd1;
   localparam logic [15:0]      NO_ERR    = 16'hFFFF;

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_FLUSH, S_READ, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0]  rd_issued_q, rd_issued_d;
   logic [IDX_W-1:0]  rd_got_q, rd_got_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              flush_zero_q, flush_zero_d;
   logic              rd_vld_q, rd_vld_d;
   logic              wr_en_d, rd_req_d, read_valid_d;
   logic              busy_d, done_d, pass_d, timeout_d;
   logic [DATA_W-1:0] wr_data_d;
   logic [15:0]       err_cnt_d, err_first_d;
   logic              push_c, pop_c, launch_c;
   logic [DATA_W-1:0] expected_c;

   // State and output registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q         <= S_IDLE;
         wr_idx_q        <= '0;
         rd_issued_q     <= '0;
         rd_got_q        <= '0;
         wd_q            <= '0;
         flush_zero_q    <= 1'b0;
         rd_vld_q        <= 1'b0;
         wr_fifo_wr_en   <= 1'b0;
         wr_fifo_wr_data <= '0;
         read_valid      <= 1'b0;
         rd_fifo_rd_req  <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         timeout         <= 1'b0;
         err_cnt         <= '0;
         err_first_idx   <= NO_ERR;
      end else begin
         state_q         <= state_d;
         wr_idx_q        <= wr_idx_d;
         rd_issued_q     <= rd_issued_d;
         rd_got_q        <= rd_got_d;
         wd_q            <= wd_d;
         flush_zero_q    <= flush_zero_d;
         rd_vld_q        <= rd_vld_d;
         wr_fifo_wr_en   <= wr_en_d;
         wr_fifo_wr_data <= wr_data_d;
         read_valid      <= read_valid_d;
         rd_fifo_rd_req  <= rd_req_d;
         busy            <= busy_d;
         done            <= done_d;
         pass            <= pass_d;
         timeout         <= timeout_d;
         err_cnt         <= err_cnt_d;
         err_first_idx   <= err_first_d;
      end
   end

   // Next-state, counters and registered-output next values
   always_comb begin
      state_d      = state_q;
      wr_idx_d     = wr_idx_q;
      rd_issued_d  = rd_issued_q;
      rd_got_d     = rd_got_q;
      wd_d         = '0;
      flush_zero_d = 1'b0;
      wr_data_d    = wr_fifo_wr_data;
      timeout_d    = timeout;
      err_cnt_d    = err_cnt;
      err_first_d  = err_first_idx;
      push_c       = 1'b0;
      pop_c        = 1'b0;
      launch_c     = 1'b0;
      expected_c   = SEED + DATA_W'(rd_got_q);

      case (state_q)
         S_IDLE:  launch_c = start & init_end;
         S_DONE:  launch_c = start;
         S_WRITE: begin
            if ((wr_fifo_num < WR_LIMIT) && (wr_idx_q < TOTAL_IDX)) begin
               push_c    = 1'b1;
               wr_data_d = SEED + DATA_W'(wr_idx_q);
               wr_idx_d  = wr_idx_q + 16'd1;
               if (wr_idx_q == LAST_IDX) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // Two zero samples in a row absorb the FIFO count latency
            if (wr_fifo_num == '0) begin
               flush_zero_d = 1'b1;
               if (flush_zero_q) state_d = S_READ;
            end
         end
         S_READ: begin
            // A pop already in flight owns one word, so a second needs two
            if ((rd_fifo_num != '0) && (rd_issued_q < TOTAL_IDX) &&
                (!rd_fifo_rd_req || (rd_fifo_num >= CNT_W'(2)))) begin
               pop_c       = 1'b1;
               rd_issued_d = rd_issued_q + 16'd1;
            end
            if (rd_vld_q) begin
               if (rd_fifo_rd_data != expected_c) begin
                  if (err_cnt != 16'hFFFF) err_cnt_d = err_cnt + 16'd1;
                  if (err_first_idx == NO_ERR) err_first_d = rd_got_q;
               end
               rd_got_d = rd_got_q + 16'd1;
               if (rd_got_q == LAST_IDX) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (launch_c) begin
         state_d     = S_WRITE;
         wr_idx_d    = '0;
         rd_issued_d = '0;
         rd_got_d    = '0;
         timeout_d   = 1'b0;
         err_cnt_d   = '0;
         err_first_d = NO_ERR;
      end

      // Watchdog: any progress restarts it; expiry aborts to DONE
      if ((state_q == S_WRITE) || (state_q == S_FLUSH) || (state_q == S_READ)) begin
         if (push_c || pop_c || (state_d != state_q)) begin
            wd_d = '0;
         end else if (wd_q == WD_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
         end else begin
            wd_d = wd_q + 20'd1;
         end
      end

      wr_en_d      = push_c;
      rd_req_d     = pop_c;
      rd_vld_d     = (state_d == S_READ) & rd_fifo_rd_req;
      read_valid_d = (state_d == S_READ);
      busy_d       = (state_d == S_WRITE) || (state_d == S_FLUSH) || (state_d == S_READ);
      done_d       = (state_d == S_DONE);
      pass_d       = (state_d == S_DONE) && !timeout_d && (err_cnt_d == 16'd0);
   end

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// Bench for sdram_traffic_checker: models the write FIFO, SDRAM store and read FIFO
// with queues, runs a table of passes and a few hand-written control sequences.
module tb_sdram_traffic_checker;

   localparam int unsigned DATA_W      = 16;
   localparam int unsigned CNT_W       = 10;
   localparam int unsigned FIFO_DEPTH  = 16;
   localparam int unsigned TOTAL_WORDS = 40;
   localparam logic [15:0] SEED        = 16'hFFF0;
   localparam int          TMO         = 1000;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n;
   logic              start, init_end;
   logic              wr_fifo_wr_en, read_valid, rd_fifo_rd_req;
   logic [DATA_W-1:0] wr_fifo_wr_data, rd_fifo_rd_data;
   logic [CNT_W-1:0]  wr_fifo_num, rd_fifo_num, wnum, rnum;
   logic              busy, done, pass, timeout;
   logic [15:0]       err_cnt, err_first_idx;

   logic              hold, stuck, clr;
   int                corrupt_idx;
   logic [15:0]       wq[$], mq[$], rq[$];
   int                push_cnt, pat_bad, fed_idx, underflow, ovf, cyc;
   int                total, bad;

   typedef struct {
      int          corrupt;
      bit          hold;
      bit          stuck;
      bit          poke;
      bit          exp_pass;
      bit          exp_to;
      logic [15:0] exp_err;
      logic [15:0] exp_first;
   } vec_t;
   vec_t tbl[6];

   always #5 sys_clk = ~sys_clk;

   assign wr_fifo_num = hold  ? CNT_W'(FIFO_DEPTH - 2) : wnum;
   assign rd_fifo_num = stuck ? '0 : rnum;

   sdram_traffic_checker #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH),
      .TOTAL_WORDS(TOTAL_WORDS), .SEED(SEED), .TIMEOUT_CYC(20'(TMO))
   ) u_dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .init_end(init_end),
      .wr_fifo_wr_en(wr_fifo_wr_en), .wr_fifo_wr_data(wr_fifo_wr_data),
      .wr_fifo_num(wr_fifo_num), .read_valid(read_valid),
      .rd_fifo_rd_req(rd_fifo_rd_req), .rd_fifo_rd_data(rd_fifo_rd_data),
      .rd_fifo_num(rd_fifo_num), .busy(busy), .done(done), .pass(pass),
      .timeout(timeout), .err_cnt(err_cnt), .err_first_idx(err_first_idx)
   );

   // FIFO/SDRAM model: write FIFO drains slowly, read FIFO fills while read_valid
   always @(posedge sys_clk) begin
      if (clr) begin
         wq.delete(); mq.delete(); rq.delete();
         push_cnt <= 0; pat_bad <= 0; fed_idx <= 0; underflow <= 0; ovf <= 0;
         cyc <= 0; wnum <= '0; rnum <= '0; rd_fifo_rd_data <= '0;
      end else begin
         cyc <= cyc + 1;
         if (wr_fifo_wr_en) begin
            wq.push_back(wr_fifo_wr_data);
            if (wr_fifo_wr_data !== 16'(SEED + 16'(push_cnt))) pat_bad <= pat_bad + 1;
            push_cnt <= push_cnt + 1;
         end
         if ((cyc % 3 == 2) && (wq.size() > 0)) mq.push_back(wq.pop_front());
         if (read_valid && (mq.size() > 0)) begin
            if (fed_idx == corrupt_idx) rq.push_back(mq.pop_front() ^ 16'h0001);
            else rq.push_back(mq.pop_front());
            fed_idx <= fed_idx + 1;
         end
         if (rd_fifo_rd_req) begin
            if (rq.size() > 0) rd_fifo_rd_data <= rq.pop_front();
            else begin
               underflow       <= underflow + 1;
               rd_fifo_rd_data <= 16'hDEAD;
            end
         end
         if (wq.size() > FIFO_DEPTH) ovf <= ovf + 1;
         wnum <= CNT_W'(wq.size());
         rnum <= CNT_W'(rq.size());
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   initial begin
      int n, rv, bp_bad;
      total = 0; bad = 0;
      sys_rst_n = 1'b0; start = 1'b0; init_end = 1'b0;
      hold = 1'b0; stuck = 1'b0; clr = 1'b1; corrupt_idx = -1;

      //            corrupt hold stuck poke pass to  err    first
      tbl[0] = '{-1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'hFFFF};
      tbl[1] = '{37, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd37};
      tbl[2] = '{ 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
      tbl[3] = '{39, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd39};
      tbl[4] = '{-1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'hFFFF};
      tbl[5] = '{-1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'hFFFF};

      // Reset values
      repeat (3) @(negedge sys_clk);
      check("rst_wr_en", 32'(wr_fifo_wr_en), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_pass", 32'(pass), 0);
      check("rst_read_valid", 32'(read_valid), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      check("rst_err_first", 32'(err_first_idx), 32'hFFFF);
      sys_rst_n = 1'b1; clr = 1'b0;
      repeat (2) @(negedge sys_clk);

      // start while init_end=0 is dropped
      start = 1'b1; @(negedge sys_clk); start = 1'b0;
      repeat (5) @(negedge sys_clk);
      check("noinit_busy", 32'(busy), 0);
      check("noinit_pushes", 32'(push_cnt), 0);

      // Reset mid-WRITE aborts asynchronously
      init_end = 1'b1; start = 1'b1; @(negedge sys_clk); start = 1'b0;
      check("launch_busy", 32'(busy), 1);
      repeat (3) @(negedge sys_clk);
      check("midwrite_wr_en", 32'(wr_fifo_wr_en), 1);
      sys_rst_n = 1'b0; clr = 1'b1; #1;
      check("async_wr_en", 32'(wr_fifo_wr_en), 0);
      check("async_busy", 32'(busy), 0);
      check("async_err_first", 32'(err_first_idx), 32'hFFFF);
      @(negedge sys_clk); sys_rst_n = 1'b1; clr = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("post_rst_idle", 32'(busy), 0);
      check("post_rst_wr_en", 32'(wr_fifo_wr_en), 0);

      // Table of passes; each start after the first comes from DONE
      for (int i = 0; i < 6; i++) begin
         corrupt_idx = tbl[i].corrupt;
         stuck = tbl[i].stuck;
         clr = 1'b1; start = 1'b1;
         @(negedge sys_clk);
         clr = 1'b0; start = 1'b0;
         check($sformatf("v%0d_busy_start", i), 32'(busy), 1);
         check($sformatf("v%0d_done_clear", i), 32'(done), 0);
         if (tbl[i].hold) begin
            for (n = 0; n < 2000 && push_cnt < 5; n++) @(negedge sys_clk);
            hold = 1'b1; bp_bad = 0;
            repeat (100) begin
               @(negedge sys_clk);
               if (wr_fifo_wr_en) bp_bad++;
            end
            hold = 1'b0;
            @(negedge sys_clk);
            check("bp_no_push", 32'(bp_bad), 0);
            check("bp_resume", 32'(wr_fifo_wr_en), 1);
         end
         if (tbl[i].poke) begin
            for (n = 0; n < 2000 && push_cnt < 10; n++) @(negedge sys_clk);
            start = 1'b1; @(negedge sys_clk); start = 1'b0;
         end
         rv = 0;
         for (n = 0; n < 20000 && !done; n++) begin
            @(negedge sys_clk);
            if (read_valid) rv++;
         end
         check($sformatf("v%0d_done", i), 32'(done), 1);
         check($sformatf("v%0d_busy", i), 32'(busy), 0);
         check($sformatf("v%0d_pass", i), 32'(pass), 32'(tbl[i].exp_pass));
         check($sformatf("v%0d_timeout", i), 32'(timeout), 32'(tbl[i].exp_to));
         check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].exp_err));
         check($sformatf("v%0d_err_first", i), 32'(err_first_idx), 32'(tbl[i].exp_first));
         check($sformatf("v%0d_read_valid", i), 32'(read_valid), 0);
         check($sformatf("v%0d_pattern", i), 32'(pat_bad), 0);
         check($sformatf("v%0d_pushes", i), 32'(push_cnt), TOTAL_WORDS);
         check($sformatf("v%0d_underflow", i), 32'(underflow), 0);
         check($sformatf("v%0d_overflow", i), 32'(ovf), 0);
         if (tbl[i].stuck) check("timeout_cycles", 32'(rv), 32'(TMO));
         else check($sformatf("v%0d_fed", i), 32'(fed_idx), TOTAL_WORDS);
      end
      stuck = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
